// File: rtl/pueo_capture_pkg.sv
// ============================================================================
// Module      : pueo_capture_pkg
// Description : Shared types and default sizes for the PUEO capture buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pueo_capture_pkg;

    localparam int c_DEFAULT_DEPTH      = 512;
    localparam int c_DEFAULT_DATA_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        READ = 2'd2
    } capture_state_t;

endpackage

`default_nettype wire

// File: rtl/pueo_capture_buffer_if.sv
// ============================================================================
// Module      : pueo_capture_buffer_if
// Description : Capture control, input sample stream and replay stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pueo_capture_buffer_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  capture_i;
    logic [DATA_WIDTH-1:0] buf_tdata;
    logic                  buf_tvalid;
    logic                  buf_tready;
    logic [DATA_WIDTH-1:0] dout_tdata;
    logic                  dout_tvalid;
    logic                  dout_tready;
    logic                  dout_tlast;
    logic                  busy_o;
    logic                  done_o;

    modport slave (
        input  capture_i, buf_tdata, buf_tvalid, dout_tready,
        output buf_tready, dout_tdata, dout_tvalid, dout_tlast, busy_o, done_o
    );

    modport master (
        output capture_i, buf_tdata, buf_tvalid, dout_tready,
        input  buf_tready, dout_tdata, dout_tvalid, dout_tlast, busy_o, done_o
    );
endinterface

`default_nettype wire

// File: rtl/pueo_capture_bram.sv
// ============================================================================
// Module      : pueo_capture_bram
// Description : Simple dual-port RAM, one write port, registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pueo_capture_bram #(
    parameter int DEPTH      = 512,
    parameter int DATA_WIDTH = 128
) (
    input  logic                       clk,
    input  logic                       i_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
    input  logic [DATA_WIDTH-1:0]      i_wr_data,
    input  logic                       i_rd_en,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_addr,
    output logic [DATA_WIDTH-1:0]      o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data_q;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data_q;

endmodule

`default_nettype wire

// File: rtl/pueo_capture_buffer.sv
// ============================================================================
// Module      : pueo_capture_buffer
// Description : Captures DEPTH valid beats into BRAM, replays them with tlast.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pueo_capture_buffer
    import pueo_capture_pkg::*;
#(
    parameter int DEPTH      = c_DEFAULT_DEPTH,
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    pueo_capture_buffer_if.slave bus
);

    localparam int             c_AW        = $clog2(DEPTH);
    localparam logic [c_AW-1:0] c_LAST_ADDR = c_AW'(DEPTH - 1);
    localparam logic [c_AW:0]   c_PTR_ONE   = (c_AW + 1)'(1);

    capture_state_t        r_state_q, w_state_d;
    logic [c_AW:0]         r_wr_ptr_q, w_wr_ptr_d;
    logic [c_AW:0]         r_rd_ptr_q, w_rd_ptr_d;
    logic                  r_rd_valid_q, w_rd_valid_d;
    logic                  r_rd_last_q, w_rd_last_d;
    logic [DATA_WIDTH-1:0] r_dout_data_q, w_dout_data_d;
    logic                  r_dout_valid_q, w_dout_valid_d;
    logic                  r_dout_last_q, w_dout_last_d;
    logic [DATA_WIDTH-1:0] r_skid_data_q, w_skid_data_d;
    logic                  r_skid_valid_q, w_skid_valid_d;
    logic                  r_skid_last_q, w_skid_last_d;
    logic                  r_busy_q, w_busy_d;
    logic                  r_done_q, w_done_d;

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_pop;
    logic [1:0]            w_pending;
    logic [DATA_WIDTH-1:0] w_rd_data;

    pueo_capture_bram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bram (
        .clk       (aclk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr_q[c_AW-1:0]),
        .i_wr_data (bus.buf_tdata),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr_q[c_AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign w_pop     = r_dout_valid_q & bus.dout_tready;
    // Entries that will occupy the skid pair once an issued read lands.
    assign w_pending = 2'(r_dout_valid_q) + 2'(r_skid_valid_q) + 2'(r_rd_valid_q) - 2'(w_pop);

    always_comb begin
        w_state_d      = r_state_q;
        w_wr_ptr_d     = r_wr_ptr_q;
        w_rd_ptr_d     = r_rd_ptr_q;
        w_rd_valid_d   = 1'b0;
        w_rd_last_d    = 1'b0;
        w_done_d       = 1'b0;
        w_wr_en        = 1'b0;
        w_rd_en        = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (bus.capture_i) begin
                    w_state_d  = FILL;
                    w_wr_ptr_d = '0;
                end
            end
            FILL: begin
                if (bus.buf_tvalid) begin
                    w_wr_en    = 1'b1;
                    w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
                    if (w_wr_ptr_d[c_AW]) begin
                        w_state_d  = READ;
                        w_rd_ptr_d = '0;
                    end
                end
            end
            READ: begin
                if (!r_rd_ptr_q[c_AW] && (w_pending < 2'd2)) begin
                    w_rd_en      = 1'b1;
                    w_rd_ptr_d   = r_rd_ptr_q + c_PTR_ONE;
                    w_rd_valid_d = 1'b1;
                    w_rd_last_d  = (r_rd_ptr_q[c_AW-1:0] == c_LAST_ADDR);
                end
                if (w_pop && r_dout_last_q) begin
                    w_state_d = IDLE;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase

        w_dout_data_d  = r_dout_data_q;
        w_dout_valid_d = r_dout_valid_q;
        w_dout_last_d  = r_dout_last_q;
        w_skid_data_d  = r_skid_data_q;
        w_skid_valid_d = r_skid_valid_q;
        w_skid_last_d  = r_skid_last_q;

        // Head slot frees up: refill from skid first, then from landing data.
        if (w_pop || !r_dout_valid_q) begin
            if (r_skid_valid_q) begin
                w_dout_data_d  = r_skid_data_q;
                w_dout_valid_d = 1'b1;
                w_dout_last_d  = r_skid_last_q;
                w_skid_valid_d = r_rd_valid_q;
                w_skid_last_d  = r_rd_valid_q & r_rd_last_q;
                if (r_rd_valid_q) begin
                    w_skid_data_d = w_rd_data;
                end
            end else begin
                w_dout_valid_d = r_rd_valid_q;
                w_dout_last_d  = r_rd_valid_q & r_rd_last_q;
                if (r_rd_valid_q) begin
                    w_dout_data_d = w_rd_data;
                end
                w_skid_valid_d = 1'b0;
                w_skid_last_d  = 1'b0;
            end
        end else if (r_rd_valid_q) begin
            w_skid_data_d  = w_rd_data;
            w_skid_valid_d = 1'b1;
            w_skid_last_d  = r_rd_last_q;
        end

        w_busy_d = (w_state_d != IDLE);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state_q      <= IDLE;
            r_wr_ptr_q     <= '0;
            r_rd_ptr_q     <= '0;
            r_rd_valid_q   <= 1'b0;
            r_rd_last_q    <= 1'b0;
            r_dout_data_q  <= '0;
            r_dout_valid_q <= 1'b0;
            r_dout_last_q  <= 1'b0;
            r_skid_data_q  <= '0;
            r_skid_valid_q <= 1'b0;
            r_skid_last_q  <= 1'b0;
            r_busy_q       <= 1'b0;
            r_done_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_wr_ptr_q     <= w_wr_ptr_d;
            r_rd_ptr_q     <= w_rd_ptr_d;
            r_rd_valid_q   <= w_rd_valid_d;
            r_rd_last_q    <= w_rd_last_d;
            r_dout_data_q  <= w_dout_data_d;
            r_dout_valid_q <= w_dout_valid_d;
            r_dout_last_q  <= w_dout_last_d;
            r_skid_data_q  <= w_skid_data_d;
            r_skid_valid_q <= w_skid_valid_d;
            r_skid_last_q  <= w_skid_last_d;
            r_busy_q       <= w_busy_d;
            r_done_q       <= w_done_d;
        end
    end

    assign bus.buf_tready  = 1'b1;
    assign bus.dout_tdata  = r_dout_data_q;
    assign bus.dout_tvalid = r_dout_valid_q;
    assign bus.dout_tlast  = r_dout_last_q;
    assign bus.busy_o      = r_busy_q;
    assign bus.done_o      = r_done_q;

endmodule

`default_nettype wire

// File: tb/tb_pueo_capture_buffer.sv
// ============================================================================
// Module      : tb_pueo_capture_buffer
// Description : Scoreboard bench for pueo_capture_buffer with DEPTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pueo_capture_buffer;

    localparam int c_DEPTH = 16;
    localparam int c_DW    = 128;

    typedef struct packed {
        logic [c_DW-1:0] data;
        logic            last;
    } exp_t;

    logic clk;
    logic aresetn;

    pueo_capture_buffer_if #(.DATA_WIDTH(c_DW)) bus ();

    pueo_capture_buffer #(
        .DEPTH      (c_DEPTH),
        .DATA_WIDTH (c_DW)
    ) dut (
        .aclk    (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    exp_t            exp_q[$];
    int              n_checks  = 0;
    int              n_fail    = 0;
    int              cycle_cnt = 0;
    int              stall_cnt = 0;
    int              beat_cnt  = 0;
    bit              rand_ready = 0;
    bit              prev_stall = 0;
    bit              exp_done   = 0;
    logic [c_DW-1:0] prev_data;
    logic            prev_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cycle_cnt++;
    end

    task automatic check(input string name, input logic [c_DW-1:0] act, input logic [c_DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle_cnt);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cycle_cnt);
    endtask

    // Downstream ready driver
    initial begin
        bus.dout_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.dout_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: sampled mid-cycle, the handshake takes effect at the next posedge
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!aresetn) begin
            prev_stall = 0;
            exp_done   = 0;
        end else begin
            if (exp_done) begin
                check("done_pulse", bus.done_o, 1);
                check("busy_at_done", bus.busy_o, 0);
                exp_done = 0;
            end else if (bus.done_o) begin
                check("spurious_done", bus.done_o, 0);
            end
            if (prev_stall) begin
                check("stall_valid", bus.dout_tvalid, 1);
                check("stall_data", bus.dout_tdata, prev_data);
                check("stall_last", bus.dout_tlast, prev_last);
            end
            if (bus.dout_tvalid && bus.dout_tready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", bus.dout_tdata, e.data);
                    check("beat_last", bus.dout_tlast, e.last);
                    if (e.last) exp_done = 1;
                end
            end
            prev_stall = bus.dout_tvalid && !bus.dout_tready;
            prev_data  = bus.dout_tdata;
            prev_last  = bus.dout_tlast;
            if (prev_stall) stall_cnt++;
        end
    end

    // Issues a capture and DEPTH stored beats starting at 'start'; returns the
    // cycle count at which the first replayed beat must be valid.
    task automatic run_fill(input logic [c_DW-1:0] start, input bit gapped, input bit same_beat,
                            input bit cap_in_fill, input bit cap_in_read, output int t_first);
        int              n;
        logic [c_DW-1:0] v;
        bit              phase;
        @(posedge clk);
        #1;
        bus.capture_i  = 1'b1;
        bus.buf_tvalid = same_beat;
        bus.buf_tdata  = start - 1;
        n     = 0;
        v     = start;
        phase = 0;
        while (n < c_DEPTH) begin
            @(posedge clk);
            #1;
            bus.capture_i = cap_in_fill && (n == 5);
            if (gapped && phase) begin
                bus.buf_tvalid = 1'b0;
                bus.buf_tdata  = 128'hDEAD;
            end else begin
                bus.buf_tvalid = 1'b1;
                bus.buf_tdata  = v;
                exp_q.push_back(exp_t'{data: v, last: (n == c_DEPTH - 1)});
                v++;
                n++;
            end
            phase = !phase;
        end
        @(posedge clk);
        #1;
        bus.capture_i  = 1'b0;
        bus.buf_tvalid = 1'b1;
        bus.buf_tdata  = 128'hBAD;
        @(negedge clk);
        check("read_entry_valid", bus.dout_tvalid, 0);
        check("read_entry_busy", bus.busy_o, 1);
        @(negedge clk);
        check("first_beat_early", bus.dout_tvalid, 0);
        @(negedge clk);
        check("first_beat_valid", bus.dout_tvalid, 1);
        t_first = cycle_cnt;
        if (cap_in_read) begin
            @(posedge clk);
            #1;
            bus.capture_i = 1'b1;
            @(posedge clk);
            #1;
            bus.capture_i = 1'b0;
        end
    endtask

    task automatic wait_done(input int t_first);
        bit seen;
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.done_o) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            fail_now("done_timeout");
        end else begin
            check("done_latency", cycle_cnt - t_first, c_DEPTH + stall_cnt);
        end
        repeat (4) @(negedge clk);
        check("idle_busy", bus.busy_o, 0);
        check("idle_valid", bus.dout_tvalid, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int  t_first;
        bit  got;
        #100000;
        $display("FAIL watchdog_timeout (cycle %0d)", cycle_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_first;
        bit got;
        aresetn        = 1'b0;
        bus.capture_i  = 1'b0;
        bus.buf_tvalid = 1'b0;
        bus.buf_tdata  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", bus.dout_tvalid, 0);
        check("rst_tlast", bus.dout_tlast, 0);
        check("rst_tdata", bus.dout_tdata, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_tready", bus.buf_tready, 1);
        @(posedge clk);
        #1;
        aresetn = 1'b1;

        // Continuous ramp: capture-cycle beat 0 discarded, 1..16 replayed
        stall_cnt = 0;
        run_fill(128'h1, 0, 1, 0, 0, t_first);
        wait_done(t_first);

        // Gapped input
        stall_cnt = 0;
        run_fill(128'h40, 1, 1, 0, 0, t_first);
        wait_done(t_first);

        // Random back-pressure
        rand_ready = 1;
        stall_cnt  = 0;
        run_fill(128'h200, 0, 1, 0, 0, t_first);
        wait_done(t_first);
        rand_ready = 0;

        // Requests during FILL and READ ignored
        stall_cnt = 0;
        run_fill(128'h300, 0, 1, 1, 1, t_first);
        wait_done(t_first);

        // Reset after beat 5 is accepted
        stall_cnt = 0;
        beat_cnt  = 0;
        run_fill(128'h500, 0, 0, 0, 0, t_first);
        got = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (beat_cnt >= 6) begin
                got = 1;
                break;
            end
        end
        if (!got) fail_now("beat5_timeout");
        @(posedge clk);
        #1;
        aresetn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(negedge clk);
        check("midrst_tvalid", bus.dout_tvalid, 0);
        check("midrst_busy", bus.busy_o, 0);
        check("midrst_tlast", bus.dout_tlast, 0);
        check("midrst_done", bus.done_o, 0);
        stall_cnt = 0;
        run_fill(128'h100, 0, 0, 0, 0, t_first);
        wait_done(t_first);

        // Same-cycle beat 0xAA dropped, replay starts at 0xAB
        stall_cnt = 0;
        run_fill(128'hAB, 0, 1, 0, 0, t_first);
        wait_done(t_first);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pueo_capture_buffer.md
# pueo_capture_buffer

Sink-side capture buffer for one 128-bit ADC sample stream. It sits downstream of the ADC-to-buffer AXI4-Stream pass-through and accepts the `buf_` stream that the pass-through drives. On a capture request it stores DEPTH consecutive valid beats in block RAM. It then replays them in order on a back-pressurable AXI4-Stream output terminated by `tlast`.

## Interface
Parameters:
- `DEPTH`, default 512: beats per capture. Power of two, ≥4.
- `DATA_WIDTH`, default 128: beat width.

Ports:
- `aclk`, in, 1: the single clock.
- `aresetn`, in, 1: reset, synchronous, active-low.
- `capture_i`, in, 1: single-cycle capture request.
- `buf_tdata`, in, DATA_WIDTH: input sample beat.
- `buf_tvalid`, in, 1: input beat valid.
- `buf_tready`, out, 1: tied to 1. The ADC path is never stalled.
- `dout_tdata`, out, DATA_WIDTH: replayed beat.
- `dout_tvalid`, out, 1: output beat valid.
- `dout_tready`, in, 1: downstream ready.
- `dout_tlast`, out, 1: high on replay beat DEPTH-1.
- `busy_o`, out, 1: high in FILL or READ.
- `done_o`, out, 1: one-cycle pulse on the final output handshake.

## Operation
States:
- **IDLE**
  - Input beats are discarded.
  - `capture_i`=1 moves the block to FILL next cycle and clears `wr_ptr`.
  - A beat presented in the same cycle as `capture_i` is not stored.
- **FILL**
  - Every cycle with `buf_tvalid`=1 writes `mem[wr_ptr]` and increments `wr_ptr`.
  - Cycles with `buf_tvalid`=0 write nothing.
  - The write of beat DEPTH-1 moves the block to READ next cycle.
- **READ**
  - Beats 0..DEPTH-1 are issued in order through a 1-cycle registered BRAM read into a 2-entry skid buffer.
  - The read address advances only when the skid buffer has space at the time the read data lands, so no beat is dropped or duplicated.
  - The accepted beat with index DEPTH-1 carries `dout_tlast`=1. After that handshake: `done_o`=1 for one cycle, then IDLE.
- `capture_i` in FILL or READ is ignored.

Output rules:
- `dout_tdata` and `dout_tlast` stay stable while `dout_tvalid`=1 and `dout_tready`=0.
- `dout_tvalid` never drops without a handshake.

Arithmetic and boundaries:
- Pointers are log2(DEPTH) bits plus a terminal flag. Wrap at DEPTH is never used for addressing.
- Memory contents are not cleared by reset or by a new capture.
- Reset mid-operation (any state): next cycle the block is in IDLE with pointers at 0, the skid buffer empty and all outputs at reset values. Stored data is left in place but will not be replayed.

Reset values:
- `dout_tvalid`=0, `dout_tlast`=0, `dout_tdata`=0.
- `busy_o`=0, `done_o`=0.
- `buf_tready`=1.

## Timing
- Capture start: `capture_i` at cycle T → `busy_o`=1 and first storable beat at T+1.
- FILL→READ: the cycle after the last write. Call it R.
- First output: `dout_tvalid`=1 at R+2.
- With `dout_tready` held at 1: one beat per cycle, with the last beat at R+1+DEPTH.
- Done: `done_o` pulses the cycle after the last handshake. `busy_o` deasserts in that same cycle.
- Minimum capture-to-capture: DEPTH (fill) + DEPTH+3 (replay) cycles with continuous valid/ready.
- Back-pressure: a ready low for N cycles delays all later beats by exactly N cycles. No bubbles are added when ready returns.

## Structure
- Shared package `pueo_capture_pkg`:
  - `capture_state_t` enum (IDLE, FILL, READ).
  - Default `DEPTH` / `DATA_WIDTH` localparams.
- Sub-module `pueo_capture_bram`: simple dual-port RAM with 1 write port and 1 read port and a registered read output, parameterized by DEPTH and DATA_WIDTH, inferable as block RAM.
- FSM, pointers, skid buffer and handshake logic live in the top module.

## Test plan
1. **Continuous ramp.** DEPTH=16, `buf_tdata`=k each cycle with `buf_tvalid`=1, `capture_i` pulse, `dout_tready`=1.
   - Outputs are the 16 values following the capture cycle, in order, on consecutive cycles starting at R+2.
   - `tlast` is on the 16th beat; `done_o` pulses once.
2. **Gapped input.** `buf_tvalid` toggling 1/0 with ramp data → exactly 16 consecutive valid values are captured; READ is entered after the 16th valid beat.
3. **Random back-pressure.** 50% random `dout_tready` → order preserved, no loss or duplication, `tdata`/`tlast` stable during every stall, `tlast` only on beat 15.
4. **Ignored requests.** `capture_i` pulsed during FILL and again during READ → a single 16-beat replay and a single `done_o`; the block returns to IDLE.
5. **Reset mid-READ.** `aresetn`=0 for one cycle after beat 5 is accepted:
   - Next cycle `dout_tvalid`=0, `busy_o`=0.
   - A following capture of value 0x100+k replays 0x100.. correctly.
6. **Same-cycle beat.** `capture_i` coinciding with beat value 0xAA followed by 0xAB.. → first replayed beat is 0xAB.
